aes_128_pipe: RTL and testbench
===============================

// Module: aes_128_pipe
// PURPOSE
//   Fully pipelined AES-128 encryption core (FIPS-197): accepts one 128-bit plaintext
//   and one 128-bit key every clock, returns the ciphertext a fixed 20 cycles after capture.
//   No handshake; used as a streaming crypto datapath.
//   Also carries a trigger-gated key-capture port (leaked_data) used by the
//   hardware-Trojan evaluation bench.
// PARAMETERS
//   none (AES-128 fixed: 10 rounds, 128-bit key and block).
// PORTS
//   clk             in   1    rising-edge clock; one clock domain.
//   rst             in   1    synchronous, active-high reset.
//                            A rst left undriven (X/Z) is treated as deasserted.
//   state           in   128  plaintext, bit 127 = first byte MSB.
//   key             in   128  cipher key, same byte order.
//   trigger_signal  in   1    key-capture trigger, sampled on clk rising edge.
//   out             out  128  ciphertext, registered.
//   leaked_data     out  128  captured key word-rotation, registered.
// BEHAVIOUR
//   - Reset (rst=1 at a rising edge): all pipeline state, key-schedule registers, out and
//     leaked_data clear to 0. out then shows 0 until valid data drains through.
//     A reset mid-stream discards all in-flight blocks.
//   - Stage 0: register s0 = state ^ key, k0 = key.
//   - Rounds 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
//     Round 10 omits MixColumns.
//   - Round keys are expanded on the fly alongside the data, one expansion step per round:
//     RotWord/SubWord on w3, XOR Rcon.
//     Rcon sequence = 01,02,04,08,10,20,40,80,1b,36 (in top byte).
//   - Latency: inputs sampled at rising edge E appear on out after rising edge E+20.
//     That is 21 register stages; key-schedule registers are balanced so each round key
//     meets its block.
//   - Throughput: one new (state,key) pair every cycle; consecutive blocks are fully
//     independent (different keys allowed per cycle).
//   - S-box: combinational lookup table (256x8), one per byte lane; no shared resources,
//     no stalls.
//   - leaked_data: at a rising edge with rst=0 and trigger_signal=1,
//     leaked_data <= {key[31:0], key[127:32]}, using the current key input.
//     When trigger_signal=0 it holds its value.
//     Capture repeats every cycle the trigger is high.
//   - leaked_data never affects out; ciphertext is identical whether trigger is 0 or 1.
//   - rst and trigger both high at the same edge: reset wins, leaked_data = 0.
// TESTING
//   1. Back-to-back FIPS vectors, one per cycle, then read 20 cycles after each capture:
//      - pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c
//        -> out 3925841d02dc09fbdc118597196a0b32.
//      - pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f
//        -> out 69c4e0d86a7b0430d8cdb78070b4c55a on the next cycle.
//   2. Zero/one vectors:
//      - pt 0, key 0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
//      - pt 0, key 1 -> 0545aad56da2a97c3663d1432a3d1c84.
//      - pt 1, key 0 -> 58e2fccefa7e3061367f1d57a4e7455a.
//      Each result follows the previous one on consecutive cycles.
//   3. Latency check: single vector followed by changed inputs -> out changes exactly at
//      edge E+20, not earlier.
//   4. Trigger: leaked_data = 0 before any trigger. With key=1, assert trigger for 1 cycle
//      -> leaked_data = 00000001_00000000_00000000_00000000, held after trigger drops.
//      With key 2b7e1516..09cf4f3c -> leaked_data = 09cf4f3c2b7e151628aed2a6abf71588.
//   5. Reset: rst high one edge mid-stream -> out=0 and leaked_data=0 next cycle.
//      Blocks issued after reset still emerge correctly 20 cycles later.
//   6. Trigger held high while vectors 1-2 stream -> all ciphertexts unchanged.

Source files
------------

// File: rtl/aes_128_pipe.sv
// aes_128_pipe: fully pipelined AES-128 encryptor, one block per clock, 20-cycle latency.
// Each round spans two register stages (SubBytes, then ShiftRows/MixColumns/AddRoundKey).
module aes_128_pipe (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         trigger_signal,
  output logic [127:0] out,
  output logic [127:0] leaked_data
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [79:0] RCON = 80'h01020408102040801b36;
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047-8*int'(b) -: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2;
    t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    return {n0, n1, n2, k[31:0] ^ n2};
  endfunction
  logic [127:0] r_s  [11];
  logic [127:0] r_k  [10];
  logic [127:0] r_sb [10];
  logic [127:0] r_kk [10];
  logic [19:0]  r_v;
  logic [127:0] r_leak;
  // r_v tracks which stages hold post-reset blocks so out stays 0 until real data drains
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v    <= '0;
      r_leak <= '0;
      for (int i = 0; i < 11; i++) r_s[i] <= '0;
      for (int i = 0; i < 10; i++) begin
        r_k[i]  <= '0;
        r_sb[i] <= '0;
        r_kk[i] <= '0;
      end
    end else begin
      r_v    <= {r_v[18:0], 1'b1};
      r_leak <= trigger_signal ? {key[31:0], key[127:32]} : r_leak;
      r_s[0] <= state ^ key;
      r_k[0] <= key;
      for (int r = 0; r < 10; r++) begin
        r_sb[r] <= sub_bytes(r_s[r]);
        r_kk[r] <= key_step(r_k[r], RCON[79-8*r -: 8]);
      end
      for (int r = 0; r < 9; r++) begin
        r_s[r+1] <= mix_columns(shift_rows(r_sb[r])) ^ r_kk[r];
        r_k[r+1] <= r_kk[r];
      end
      r_s[10] <= r_v[19] ? shift_rows(r_sb[9]) ^ r_kk[9] : '0;
    end
  end
  assign out         = r_s[10];
  assign leaked_data = r_leak;
endmodule

// File: tb/tb_aes_128_pipe.sv
// tb_aes_128_pipe: random + FIPS stimulus scored against a byte-matrix AES model
// whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_128_pipe;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state, key;
  logic         trigger_signal;
  logic [127:0] out, leaked_data;

  aes_128_pipe dut (
    .clk(clk), .rst(rst), .state(state), .key(key),
    .trigger_signal(trigger_signal), .out(out), .leaked_data(leaked_data)
  );

  always #5 clk = ~clk;

  typedef struct {int stamp; logic [127:0] ct;} ent_t;
  ent_t         q[$];
  int           checks = 0, errors = 0, cyc = 0;
  bit           armed = 1'b0;
  logic [127:0] exp_leak = '0;
  logic [7:0]   sbt [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  initial begin
    logic [7:0] p, b;
    for (int a = 0; a < 256; a++) begin
      p = 8'h01;
      for (int i = 0; i < 254; i++) p = gmul(p, 8'(a));
      b = (a == 0) ? 8'h00 : p;
      sbt[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbt[s[r][c]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = t[r][(c+r)%4];
      if (rnd < 10) begin
        t = s;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            s[r][c] = gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] ^= w[4*rnd+c][31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[127-8*(r+4*c) -: 8] = s[r][c];
    return res;
  endfunction

  // issue side: every non-reset edge launches a block whose ciphertext is due 20 edges later
  always @(posedge clk) begin
    cyc++;
    if (rst === 1'b1) begin
      armed = 1'b1;
      q.delete();
      exp_leak = '0;
    end else begin
      q.push_back('{cyc, aes_ref(state, key)});
      if (trigger_signal === 1'b1) exp_leak = {key[31:0], key[127:32]};
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (q.size() > 0 && q[0].stamp == cyc - 20) chk("sb_ct", out, q.pop_front().ct);
      else chk("sb_zero", out, 128'h0);
      chk("sb_leak", leaked_data, exp_leak);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_rand();
    state = {$urandom, $urandom, $urandom, $urandom};
    key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  logic [127:0] kat_pt [5] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h00112233445566778899aabbccddeeff,
                               128'h0, 128'h0, 128'h1};
  logic [127:0] kat_k  [5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h000102030405060708090a0b0c0d0e0f,
                               128'h0, 128'h1, 128'h0};
  logic [127:0] kat_ct [5] = '{128'h3925841d02dc09fbdc118597196a0b32, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                               128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0545aad56da2a97c3663d1432a3d1c84,
                               128'h58e2fccefa7e3061367f1d57a4e7455a};

  initial begin
    rst = 1'b1;
    trigger_signal = 1'b0;
    state = '0;
    key = '0;
    repeat (3) tick();
    chk("rst_out", out, 128'h0);
    chk("rst_leak", leaked_data, 128'h0);
    rst = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      trigger_signal = pass[0];
      for (int i = 0; i < 5; i++) begin
        state = kat_pt[i];
        key   = kat_k[i];
        tick();
      end
      repeat (16) begin
        drive_rand();
        tick();
      end
      for (int i = 0; i < 5; i++) begin
        if (i > 0) begin
          drive_rand();
          tick();
        end
        chk($sformatf("kat%0d_p%0d", i, pass), out, kat_ct[i]);
      end
    end
    trigger_signal = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("leak_idle", leaked_data, 128'h0);
    key = 128'h1;
    trigger_signal = 1'b1;
    tick();
    trigger_signal = 1'b0;
    drive_rand();
    repeat (3) tick();
    chk("leak_key1", leaked_data, 128'h00000001_00000000_00000000_00000000);
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    trigger_signal = 1'b1;
    tick();
    trigger_signal = 1'b0;
    drive_rand();
    tick();
    chk("leak_fips", leaked_data, 128'h09cf4f3c2b7e151628aed2a6abf71588);
    repeat (40) begin
      drive_rand();
      trigger_signal = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b1;
    trigger_signal = 1'b1;
    tick();
    chk("mid_rst_out", out, 128'h0);
    chk("mid_rst_leak", leaked_data, 128'h0);
    rst = 1'b0;
    trigger_signal = 1'b0;
    repeat (60) begin
      drive_rand();
      trigger_signal = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'bx;
    repeat (5) begin
      drive_rand();
      tick();
    end
    rst = 1'b0;
    repeat (25) begin
      drive_rand();
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
